// File: rtl/reset_sequencer_if.sv
// Status and control bundle between the reset sequencer and its environment.
// The sequencer takes the slave side; whatever drives PLL status and soft requests takes the master side.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 8
);
    logic                  pll_locked;
    logic                  soft_req;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  ready;
    logic [1:0]            state;
    logic [CNT_W-1:0]      reset_count;

    modport master (
        output pll_locked, soft_req,
        input  rst_out, ready, state, reset_count
    );

    modport slave (
        input  pll_locked, soft_req,
        output rst_out, ready, state, reset_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on / soft-reset sequencer: qualifies PLL lock, holds every domain in reset for a delay,
// then releases the stages one after another and counts how often the RUN state is left.
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int DELAY       = 20'hFFFFF,
    parameter int STAGE_GAP   = 16,
    parameter int CNT_W       = 8
) (
    input  logic               clk_sys,
    input  logic               RESET_N,
    reset_sequencer_if.slave   seq
);
    localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);
    localparam int DELAY_W = $clog2(DELAY + 1);
    localparam int GAP_W   = $clog2(STAGE_GAP + 1);
    localparam int IDX_W   = $clog2(NUM_STAGES + 1);

    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(DELAY - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]   IDX_DONE   = IDX_W'(NUM_STAGES);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LOCK_W-1:0]     lock_cnt, lock_d;
    logic [DELAY_W-1:0]    delay_cnt, delay_d;
    logic [GAP_W-1:0]      gap_cnt, gap_d;
    logic [IDX_W-1:0]      stage_idx, idx_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  ready_q, ready_d;
    logic [CNT_W-1:0]      count_q, count_d;

    always_ff @(posedge clk_sys) begin
        if (!RESET_N) begin
            state_q   <= WAIT_LOCK;
            lock_cnt  <= '0;
            delay_cnt <= '0;
            gap_cnt   <= '0;
            stage_idx <= '0;
            rst_q     <= '1;
            ready_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            lock_cnt  <= lock_d;
            delay_cnt <= delay_d;
            gap_cnt   <= gap_d;
            stage_idx <= idx_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_cnt;
        delay_d = delay_cnt;
        gap_d   = gap_cnt;
        idx_d   = stage_idx;
        rst_d   = rst_q;
        ready_d = ready_q;
        count_d = count_q;

        if (state_q == WAIT_LOCK) begin
            rst_d   = '1;
            ready_d = 1'b0;
            if (!seq.pll_locked) begin
                lock_d = '0;
            end else if (lock_cnt == LOCK_LAST) begin
                state_d = HOLD;
                lock_d  = '0;
                delay_d = '0;
            end else begin
                lock_d = lock_cnt + 1'b1;
            end
        end else if (!seq.pll_locked) begin
            // Lock loss outranks a coincident soft request and forces re-qualification.
            state_d = WAIT_LOCK;
            lock_d  = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            if (state_q == RUN && count_q != '1) count_d = count_q + 1'b1;
        end else if (seq.soft_req) begin
            state_d = HOLD;
            delay_d = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            if (state_q == RUN && count_q != '1) count_d = count_q + 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    if (delay_cnt == DELAY_LAST) begin
                        state_d  = RELEASE;
                        rst_d[0] = 1'b0;
                        gap_d    = '0;
                        idx_d    = IDX_W'(1);
                    end else begin
                        delay_d = delay_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_d = '0;
                        if (stage_idx == IDX_DONE) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            for (int k = 0; k < NUM_STAGES; k++) begin
                                if (IDX_W'(k) == stage_idx) rst_d[k] = 1'b0;
                            end
                            idx_d = stage_idx + 1'b1;
                        end
                    end else begin
                        gap_d = gap_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign seq.rst_out     = rst_q;
    assign seq.ready       = ready_q;
    assign seq.state       = state_q;
    assign seq.reset_count = count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a timeline model (edges since hold entry) checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_reset_sequencer;
    localparam int NS    = 3;
    localparam int LOCK  = 4;
    localparam int DLY   = 10;
    localparam int GAP   = 3;
    localparam int CW    = 2;
    localparam int TOTAL = DLY + NS * GAP;

    logic clk_sys = 1'b0;
    logic RESET_N;
    always #5 clk_sys = ~clk_sys;

    reset_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

    reset_sequencer #(
        .NUM_STAGES (NS),
        .LOCK_CYCLES(LOCK),
        .DELAY      (DLY),
        .STAGE_GAP  (GAP),
        .CNT_W      (CW)
    ) dut (
        .clk_sys(clk_sys),
        .RESET_N(RESET_N),
        .seq    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: either qualifying lock (run of consecutive 1s) or sequencing (edges since hold entry).
    bit m_valid = 1'b0;
    bit m_seq   = 1'b0;
    int m_run   = 0;
    int m_elapsed = 0;
    int m_count = 0;

    always @(posedge clk_sys) begin
        if (!RESET_N) begin
            m_valid   = 1'b1;
            m_seq     = 1'b0;
            m_run     = 0;
            m_elapsed = 0;
            m_count   = 0;
        end else if (!m_seq) begin
            if (bus.pll_locked) begin
                m_run++;
                if (m_run == LOCK) begin
                    m_seq     = 1'b1;
                    m_elapsed = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (!bus.pll_locked) begin
                if (m_elapsed >= TOTAL && m_count < (1 << CW) - 1) m_count++;
                m_seq = 1'b0;
                m_run = 0;
            end else if (bus.soft_req) begin
                if (m_elapsed >= TOTAL && m_count < (1 << CW) - 1) m_count++;
                m_elapsed = 0;
            end else if (m_elapsed < TOTAL) begin
                m_elapsed++;
            end
        end
    end

    function automatic logic [NS-1:0] exp_rst();
        logic [NS-1:0] r;
        for (int k = 0; k < NS; k++) r[k] = !m_seq || (m_elapsed < DLY + k * GAP);
        return r;
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_seq) return 2'd0;
        if (m_elapsed < DLY) return 2'd1;
        if (m_elapsed >= TOTAL) return 2'd3;
        return 2'd2;
    endfunction

    always @(negedge clk_sys) begin
        if (m_valid) begin
            checks++;
            if (bus.rst_out !== exp_rst()) begin
                errors++;
                $display("[TB] FAIL model_rst_out t=%0t got=%b want=%b", $time, bus.rst_out, exp_rst());
            end
            checks++;
            if (bus.ready !== (m_seq && m_elapsed >= TOTAL)) begin
                errors++;
                $display("[TB] FAIL model_ready t=%0t got=%b want=%b", $time, bus.ready, (m_seq && m_elapsed >= TOTAL));
            end
            checks++;
            if (bus.state !== exp_state()) begin
                errors++;
                $display("[TB] FAIL model_state t=%0t got=%0d want=%0d", $time, bus.state, exp_state());
            end
            checks++;
            if (bus.reset_count !== CW'(m_count)) begin
                errors++;
                $display("[TB] FAIL model_reset_count t=%0t got=%0d want=%0d", $time, bus.reset_count, m_count);
            end
        end
    end

    task automatic apply_stimulus(input logic rn, input logic lk, input logic sr, input int n);
        RESET_N        = rn;
        bus.pll_locked = lk;
        bus.soft_req   = sr;
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check_output(input string name, input logic [NS-1:0] rst, input logic rdy,
                                input logic [1:0] st, input int cnt);
        checks++;
        if (bus.rst_out !== rst || bus.ready !== rdy || bus.state !== st || bus.reset_count !== CW'(cnt)) begin
            errors++;
            $display("[TB] FAIL %s got rst=%b rdy=%b st=%0d cnt=%0d want rst=%b rdy=%b st=%0d cnt=%0d",
                     name, bus.rst_out, bus.ready, bus.state, bus.reset_count, rst, rdy, st, cnt);
        end
    endtask

    initial begin
        // Power-up with lock held high.
        apply_stimulus(1'b0, 1'b1, 1'b0, 5);
        check_output("reset_state", 3'b111, 1'b0, 2'd0, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 3);
        check_output("pu_still_wait", 3'b111, 1'b0, 2'd0, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1);
        check_output("pu_hold", 3'b111, 1'b0, 2'd1, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 9);
        check_output("pu_hold_end", 3'b111, 1'b0, 2'd1, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1);
        check_output("pu_stage0", 3'b110, 1'b0, 2'd2, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 3);
        check_output("pu_stage1", 3'b100, 1'b0, 2'd2, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 3);
        check_output("pu_stage2", 3'b000, 1'b0, 2'd2, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 3);
        check_output("pu_run", 3'b000, 1'b1, 2'd3, 0);

        // Lock glitch while qualifying.
        apply_stimulus(1'b0, 1'b1, 1'b0, 2);
        apply_stimulus(1'b1, 1'b1, 1'b0, 3);
        check_output("glitch_pre", 3'b111, 1'b0, 2'd0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1);
        check_output("glitch_low", 3'b111, 1'b0, 2'd0, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 3);
        check_output("glitch_three", 3'b111, 1'b0, 2'd0, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1);
        check_output("glitch_hold", 3'b111, 1'b0, 2'd1, 0);

        // Lock loss in the middle of the release phase.
        apply_stimulus(1'b1, 1'b1, 1'b0, 10);
        check_output("loss_pre", 3'b110, 1'b0, 2'd2, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1);
        check_output("loss_wait", 3'b111, 1'b0, 2'd0, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4);
        check_output("loss_rehold", 3'b111, 1'b0, 2'd1, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 10);
        check_output("loss_stage0", 3'b110, 1'b0, 2'd2, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 6);
        check_output("loss_stage2", 3'b000, 1'b0, 2'd2, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 3);
        check_output("loss_run", 3'b000, 1'b1, 2'd3, 0);

        // Soft reset from RUN skips lock qualification.
        apply_stimulus(1'b1, 1'b1, 1'b1, 1);
        check_output("soft_hold", 3'b111, 1'b0, 2'd1, 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 9);
        check_output("soft_hold_end", 3'b111, 1'b0, 2'd1, 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1);
        check_output("soft_stage0", 3'b110, 1'b0, 2'd2, 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 9);
        check_output("soft_run", 3'b000, 1'b1, 2'd3, 1);

        // Soft request and lock loss together: lock loss wins.
        apply_stimulus(1'b1, 1'b0, 1'b1, 1);
        check_output("both_wait", 3'b111, 1'b0, 2'd0, 2);
        apply_stimulus(1'b1, 1'b1, 1'b0, 23);
        check_output("both_rerun", 3'b000, 1'b1, 2'd3, 2);

        // Counter saturation, then reset in the middle of HOLD.
        apply_stimulus(1'b0, 1'b1, 1'b0, 2);
        check_output("sat_cleared", 3'b111, 1'b0, 2'd0, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 23);
        check_output("sat_run", 3'b000, 1'b1, 2'd3, 0);
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b1, 1);
            check_output($sformatf("sat_soft%0d", i), 3'b111, 1'b0, 2'd1, (i < 3) ? i : 3);
            apply_stimulus(1'b1, 1'b1, 1'b0, 19);
            check_output($sformatf("sat_run%0d", i), 3'b000, 1'b1, 2'd3, (i < 3) ? i : 3);
        end
        apply_stimulus(1'b1, 1'b1, 1'b1, 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 5);
        check_output("sat_mid_hold", 3'b111, 1'b0, 2'd1, 3);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1);
        check_output("sat_reset", 3'b111, 1'b0, 2'd0, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
